pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Sequences the IF/ID/EX front end of the TISC pipeline. Owns the PC and generates the IFID enable/flush and ID/EX enable/bubble controls.
//  Stalls on RAW memory-address hazards between the ID and EX stages, and redirects/flushes on taken EX branches.
//  Freezes everything on external memory stall, and enters a sticky halt on a branch to HALT_PC.
// PARAMETERS
//  ADDR_W      8      width of PC and memory addresses
//  PC_STEP     3      PC increment per sequential instruction (three address fields)
//  RESET_PC    8'h00  PC value after reset
//  HALT_PC     8'hFF  branch target that halts the machine
//  HAZ_CYCLES  2      stall cycles per detected hazard (>=1)
//  CNT_W       16     width of stall performance counter
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous active-low reset
//  ext_stall       in   1       memory busy: freeze whole front end
//  id_valid        in   1       IFID holds a real instruction
//  id_read_addr    in   ADDR_W  IFID read address field
//  id_write_addr   in   ADDR_W  IFID write address field
//  ex_valid        in   1       EX stage holds a real instruction
//  ex_write_addr   in   ADDR_W  address EX instruction will write
//  ex_branch_taken in   1       EX resolved branch as taken
//  ex_branch_target in  ADDR_W  EX branch target
//  pc              out  ADDR_W  current fetch address (registered)
//  pc_en           out  1       PC advances this cycle
//  ifid_en         out  1       IFID register enable
//  ifid_flush      out  1       IFID loads a bubble (overrides ifid_en)
//  idex_en         out  1       ID/EX register enable
//  idex_bubble     out  1       ID/EX loads a bubble instead of ID contents
//  halted          out  1       machine halted (sticky)
//  stall_cycles    out  CNT_W   saturating count of stalled cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=RUN, hold_cnt=0, stall_cycles=0, halted=0.
//  While rst_n=0, force pc_en=ifid_en=idex_en=0 and ifid_flush=idex_bubble=1.
//  Control outputs are combinational from state + inputs. pc, state, counters update on posedge clk.
//  hazard = id_valid & ex_valid & (id_read_addr==ex_write_addr | id_write_addr==ex_write_addr)
//  branch = ex_valid & ex_branch_taken. Priority: ext_stall > branch > hazard.
//  FSM states: RUN, HOLD, HALTED.
//  RUN, ext_stall=1: pc_en=ifid_en=idex_en=0, flush=bubble=0. Nothing changes. Pending branch/hazard are re-evaluated after release.
//  RUN, branch:
//    - target!=HALT_PC: pc<=target, ifid_flush=1, idex_en=1, idex_bubble=1; stay RUN (any hazard ignored).
//    - target==HALT_PC: same flush, pc<=HALT_PC, go HALTED.
//  RUN, hazard: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1.
//    - HAZ_CYCLES>1: go HOLD with hold_cnt=HAZ_CYCLES-2.
//    - HAZ_CYCLES==1: stay RUN.
//  RUN, none: pc_en=ifid_en=idex_en=1; pc<=pc+PC_STEP, mod 2^ADDR_W (wraps, no flag).
//  HOLD: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1.
//    - hold_cnt==0: go RUN. Otherwise hold_cnt decrements.
//    - ext_stall in HOLD freezes hold_cnt and forces idex_en=0.
//    - branch in HOLD acts exactly as in RUN and exits to RUN/HALTED.
//  HALTED: pc frozen, pc_en=ifid_en=0, idex_en=1, idex_bubble=1, halted=1. Only reset exits.
//  Stall counting: stall_cycles increments when pc_en=0 in RUN/HOLD (incl. ext_stall); saturates at all-ones; not counted in HALTED.
//  Hazard stall total = HAZ_CYCLES cycles, including the detection cycle.
// TESTING
//  Sequential fetch: reset release, no hazards -> pc 00,03,06,09,0C on consecutive edges; pc_en=ifid_en=1.
//  Reset mid-run: drop rst_n in HOLD with stall_cycles=5 -> immediately pc=00, state RUN, stall_cycles=0, ifid_flush=1, pc_en=0.
//  Hazard: id_read_addr=10, ex_write_addr=10, ex_valid=1, HAZ_CYCLES=2 -> pc_en=0 and idex_bubble=1 for exactly 2 cycles, then pc resumes +3; stall_cycles +2.
//  Branch vs hazard: ex_branch_taken=1, target=40 with hazard also true -> next pc=40, ifid_flush=1 one cycle, no HOLD entry.
//  ext_stall: assert during HOLD for 3 cycles, then a branch under ext_stall -> HOLD extended by 3; branch applied first cycle after release; stall_cycles counts all.
//  Wrap/halt: pc=FE, no hazard -> pc=01; later branch to FF -> halted=1, pc=FF held for 10 cycles until rst_n.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// TISC front-end sequencer: owns the PC and drives IFID/IDEX enables.
// Handles RAW address hazards, taken branches, memory stalls and halt.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   ext_stall         memory busy, freezes the whole front end
//   id_valid          IFID holds a real instruction
//   id_read_addr      IFID read address field
//   id_write_addr     IFID write address field
//   ex_valid          EX stage holds a real instruction
//   ex_write_addr     address the EX instruction will write
//   ex_branch_taken   EX resolved its branch as taken
//   ex_branch_target  EX branch target
//   pc                current fetch address (registered)
//   pc_en             PC advances this cycle
//   ifid_en           IFID register enable
//   ifid_flush        IFID loads a bubble (overrides ifid_en)
//   idex_en           ID/EX register enable
//   idex_bubble       ID/EX loads a bubble instead of ID contents
//   halted            sticky halt indication
//   stall_cycles      saturating count of stalled cycles

module pipeline_ctrl #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          PC_STEP    = 3,
  parameter logic [ADDR_W-1:0]    RESET_PC   = 8'h00,
  parameter logic [ADDR_W-1:0]    HALT_PC    = 8'hFF,
  parameter int unsigned          HAZ_CYCLES = 2,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_read_addr,
  input  logic [ADDR_W-1:0] id_write_addr,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_write_addr,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  // hold_cnt only needs to reach HAZ_CYCLES-2
  localparam int unsigned HW =
    (HAZ_CYCLES > 2) ? $clog2(HAZ_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_INIT =
    HW'((HAZ_CYCLES > 1) ? (HAZ_CYCLES - 2) : 0);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]  stall_q;

  logic hazard;
  logic branch;
  logic to_halt;

  logic pc_en_c;
  logic ifid_en_c;
  logic ifid_flush_c;
  logic idex_en_c;
  logic idex_bubble_c;
  logic stall_c;

  assign hazard = id_valid & ex_valid &
                  ((id_read_addr  == ex_write_addr) |
                   (id_write_addr == ex_write_addr));

  assign branch  = ex_valid & ex_branch_taken;
  assign to_halt = (ex_branch_target == HALT_PC);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_en_c     = 1'b0;
    idex_bubble_c = 1'b0;
    stall_c       = 1'b0;

    unique case (state_q)
      S_RUN, S_HOLD: begin
        if (ext_stall) begin
          // Full freeze; a held bubble stays a bubble.
          idex_bubble_c = (state_q == S_HOLD);
        end else if (branch) begin
          pc_en_c       = 1'b1;
          ifid_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          pc_d          = ex_branch_target;
          state_d       = to_halt ? S_HALTED : S_RUN;
        end else if (state_q == S_HOLD) begin
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          if (hold_q == '0) begin
            state_d = S_RUN;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end else if (hazard) begin
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          // Detection cycle is the first stall cycle.
          if (HAZ_CYCLES > 1) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end
        end else begin
          pc_en_c   = 1'b1;
          ifid_en_c = 1'b1;
          idex_en_c = 1'b1;
          pc_d      = pc_q + STEP;
        end
        stall_c = ~pc_en_c;
      end
      S_HALTED: begin
        idex_en_c     = 1'b1;
        idex_bubble_c = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      if (stall_c && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  // Reset forces a safe, bubbling front end.
  assign pc_en        = rst_n & pc_en_c;
  assign ifid_en      = rst_n & ifid_en_c;
  assign idex_en      = rst_n & idex_en_c;
  assign ifid_flush   = ~rst_n | ifid_flush_c;
  assign idex_bubble  = ~rst_n | idex_bubble_c;
  assign halted       = (state_q == S_HALTED);
  assign pc           = pc_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl.
// Linear stimulus with hand-computed expectations.

module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ext_stall;
  logic        id_valid;
  logic [7:0]  id_read_addr;
  logic [7:0]  id_write_addr;
  logic        ex_valid;
  logic [7:0]  ex_write_addr;
  logic        ex_branch_taken;
  logic [7:0]  ex_branch_target;
  logic [7:0]  pc;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        halted;
  logic [15:0] stall_cycles;

  int pass_cnt;
  int total_cnt;

  pipeline_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ext_stall        (ext_stall),
    .id_valid         (id_valid),
    .id_read_addr     (id_read_addr),
    .id_write_addr    (id_write_addr),
    .ex_valid         (ex_valid),
    .ex_write_addr    (ex_write_addr),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .pc               (pc),
    .pc_en            (pc_en),
    .ifid_en          (ifid_en),
    .ifid_flush       (ifid_flush),
    .idex_en          (idex_en),
    .idex_bubble      (idex_bubble),
    .halted           (halted),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid        = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  initial begin
    pass_cnt         = 0;
    total_cnt        = 0;
    rst_n            = 1'b0;
    ext_stall        = 1'b0;
    id_valid         = 1'b0;
    id_read_addr     = 8'h00;
    id_write_addr    = 8'h00;
    ex_valid         = 1'b0;
    ex_write_addr    = 8'h00;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 8'h00;
    #2;
    chk("rst_pc", pc, 32'h00);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_idex_en", idex_en, 0);
    chk("rst_flush", ifid_flush, 1);
    chk("rst_bubble", idex_bubble, 1);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_cycles, 0);

    // Sequential fetch
    tick();
    rst_n = 1'b1;
    #1;
    chk("seq_pc_en", pc_en, 1);
    chk("seq_ifid_en", ifid_en, 1);
    chk("seq_pc0", pc, 32'h00);
    tick(); chk("seq_pc1", pc, 32'h03);
    tick(); chk("seq_pc2", pc, 32'h06);
    tick(); chk("seq_pc3", pc, 32'h09);
    tick(); chk("seq_pc4", pc, 32'h0C);

    // Hazard: two stall cycles
    id_valid      = 1'b1;
    id_read_addr  = 8'h10;
    id_write_addr = 8'h20;
    ex_valid      = 1'b1;
    ex_write_addr = 8'h10;
    #1;
    chk("haz_pc_en", pc_en, 0);
    chk("haz_ifid_en", ifid_en, 0);
    chk("haz_bubble", idex_bubble, 1);
    chk("haz_idex_en", idex_en, 1);
    tick();
    clr_ex();
    #1;
    chk("hold_pc", pc, 32'h0C);
    chk("hold_pc_en", pc_en, 0);
    chk("hold_bubble", idex_bubble, 1);
    chk("hold_stall", stall_cycles, 1);
    tick();
    chk("resume_pc_en", pc_en, 1);
    chk("resume_bubble", idex_bubble, 0);
    chk("resume_stall", stall_cycles, 2);
    tick();
    chk("resume_pc", pc, 32'h0F);

    // Branch beats hazard
    ex_valid         = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 8'h40;
    #1;
    chk("br_flush", ifid_flush, 1);
    chk("br_bubble", idex_bubble, 1);
    tick();
    clr_ex();
    #1;
    chk("br_pc", pc, 32'h40);
    chk("br_flush_off", ifid_flush, 0);
    chk("br_no_hold", pc_en, 1);
    chk("br_stall", stall_cycles, 2);
    tick();
    chk("br_next_pc", pc, 32'h43);

    // ext_stall inside HOLD, then branch under ext_stall
    ex_valid = 1'b1;
    #1;
    tick();
    clr_ex();
    ext_stall = 1'b1;
    #1;
    chk("xs_pc_en", pc_en, 0);
    chk("xs_idex_en", idex_en, 0);
    chk("xs_flush", ifid_flush, 0);
    chk("xs_stall0", stall_cycles, 3);
    tick(); tick(); tick();
    chk("xs_stall3", stall_cycles, 6);
    chk("xs_pc", pc, 32'h43);
    ex_valid         = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 8'h80;
    #1;
    chk("xs_br_held", ifid_flush, 0);
    tick();
    chk("xs_br_stall", stall_cycles, 7);
    chk("xs_br_pc", pc, 32'h43);
    ext_stall = 1'b0;
    #1;
    chk("xs_rel_flush", ifid_flush, 1);
    tick();
    clr_ex();
    #1;
    chk("xs_rel_pc", pc, 32'h80);
    chk("xs_rel_pc_en", pc_en, 1);
    chk("xs_rel_stall", stall_cycles, 7);

    // Reset while in HOLD
    ex_valid = 1'b1;
    #1;
    tick();
    clr_ex();
    #1;
    chk("pre_rst_stall", stall_cycles, 8);
    chk("pre_rst_pc", pc, 32'h80);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h00);
    chk("mid_rst_stall", stall_cycles, 0);
    chk("mid_rst_flush", ifid_flush, 1);
    chk("mid_rst_pc_en", pc_en, 0);
    tick();
    rst_n    = 1'b1;
    id_valid = 1'b0;
    #1;
    chk("post_rst_pc_en", pc_en, 1);

    // Wrap and halt
    ex_valid         = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 8'hFE;
    tick();
    clr_ex();
    #1;
    chk("wrap_pre", pc, 32'hFE);
    tick();
    chk("wrap_pc", pc, 32'h01);
    ex_valid         = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 8'hFF;
    #1;
    chk("halt_flush", ifid_flush, 1);
    tick();
    clr_ex();
    #1;
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 32'hFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold_pc", pc, 32'hFF);
      chk("halt_hold_flag", halted, 1);
      chk("halt_hold_pc_en", pc_en, 0);
    end
    chk("halt_stall", stall_cycles, 0);
    rst_n = 1'b0;
    #1;
    chk("unhalt_flag", halted, 0);
    chk("unhalt_pc", pc, 32'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
